// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and frame/timing helpers shared by
// the UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned START_BITS = 1;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned CNT_W      = 24;

  function automatic logic [CNT_W-1:0] pulse_duration(
    input logic [27:0] clk_hz,
    input logic [23:0] baud
  );
    return CNT_W'(clk_hz / {4'd0, baud});
  endfunction

  function automatic int unsigned frame_bits(
    input logic [1:0] stop
  );
    return START_BITS + DATA_BITS + 32'(stop);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period down-counter; tick marks the last
// cycle of each period, reload restarts a full period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter logic [CNT_W-1:0] period = 24'd12
) (
  input  logic uart_clock,
  input  logic uart_reset,
  input  logic reload,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = period - 24'd1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge uart_clock) begin
    if (!uart_reset) begin
      count <= '0;
    end else if (reload || count == '0) begin
      count <= LAST;
    end else begin
      count <= count - 24'd1;
    end
  end

  assign tick = !reload && (count == '0);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 serial transmitter with a byte-wide
// valid/ready upstream and an idle-high line.
module uart_tx
  import uart_pkg::*;
#(
  parameter logic [23:0] baud_rate  = 24'd4000000,
  parameter logic [27:0] clock_freq = 28'd50000000,
  parameter logic [1:0]  stop_bits  = 2'd1
) (
  input  logic       uart_clock,
  input  logic       uart_reset,
  input  logic [7:0] uart_d_in,
  input  logic       uart_valid,
  output logic       uart_ready,
  output logic       uart_tx_out,
  output logic       uart_busy,
  output logic       uart_done
);

  localparam logic [CNT_W-1:0] PULSE =
    pulse_duration(clock_freq, baud_rate);
  localparam int unsigned FRAME = frame_bits(stop_bits);
  localparam logic [3:0] LAST_BIT = 4'(FRAME - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS);

  if (PULSE < 24'd2) begin : g_bad_pulse
    $error("uart_tx: clock_freq/baud_rate must be >= 2");
  end

  if (stop_bits != 2'd1 && stop_bits != 2'd2) begin : g_bad_stop
    $error("uart_tx: stop_bits must be 1 or 2");
  end

  uart_state_t state;
  uart_state_t state_nxt;
  logic [7:0]  shift_q;
  logic [7:0]  shift_nxt;
  logic [3:0]  bit_q;
  logic [3:0]  bit_nxt;
  logic        ready_q;
  logic        ready_nxt;
  logic        done_q;
  logic        done_nxt;
  logic        tick;
  logic        accept;

  assign accept = uart_valid & ready_q;

  uart_baud_tick #(
    .period(PULSE)
  ) u_tick (
    .uart_clock(uart_clock),
    .uart_reset(uart_reset),
    .reload    (state == ST_IDLE),
    .tick      (tick)
  );

  always_ff @(posedge uart_clock) begin
    if (!uart_reset) begin
      state   <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      shift_q <= shift_nxt;
      bit_q   <= bit_nxt;
      ready_q <= ready_nxt;
      done_q  <= done_nxt;
    end
  end

  // bit_q counts frame bits: 0 start, 1..8 data, then stop bits
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    bit_nxt   = bit_q;
    ready_nxt = ready_q;
    done_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        ready_nxt = 1'b1;
        if (accept) begin
          state_nxt = ST_START;
          shift_nxt = uart_d_in;
          bit_nxt   = '0;
          ready_nxt = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_nxt = ST_DATA;
          bit_nxt   = 4'd1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_nxt = {1'b0, shift_q[7:1]};
          bit_nxt   = bit_q + 4'd1;
          if (bit_q == LAST_DATA) begin
            state_nxt = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
            ready_nxt = 1'b1;
          end else begin
            bit_nxt = bit_q + 4'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    uart_tx_out = 1'b1;
    unique case (state)
      ST_IDLE:  uart_tx_out = 1'b1;
      ST_START: uart_tx_out = 1'b0;
      ST_DATA:  uart_tx_out = shift_q[0];
      ST_STOP:  uart_tx_out = 1'b1;
    endcase
  end

  assign uart_ready = ready_q;
  assign uart_busy  = (state != ST_IDLE);
  assign uart_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of framing, handshake, reset and
// stop-bit length for uart_tx at 12 clocks per bit.
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] d_in;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;

  logic [7:0] d_in2;
  logic       valid2;
  logic       ready2;
  logic       tx2;
  logic       busy2;
  logic       done2;

  int tests;
  int fails;
  int done_cnt;

  uart_tx dut (
    .uart_clock (clk),
    .uart_reset (rst_n),
    .uart_d_in  (d_in),
    .uart_valid (valid),
    .uart_ready (ready),
    .uart_tx_out(tx),
    .uart_busy  (busy),
    .uart_done  (done)
  );

  uart_tx #(
    .stop_bits(2'd2)
  ) dut2 (
    .uart_clock (clk),
    .uart_reset (rst_n),
    .uart_d_in  (d_in2),
    .uart_valid (valid2),
    .uart_ready (ready2),
    .uart_tx_out(tx2),
    .uart_busy  (busy2),
    .uart_done  (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered one step after the accepting edge (E0+1); returns at
  // E121+1. Samples every bit at mid-period and rebuilds the byte.
  task automatic frame(input logic [7:0] b, input bit noise);
    logic [7:0] rx;
    logic       e;
    int         n;
    rx = '0;
    for (int k = 0; k < 10; k++) begin
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      n = (k == 0) ? 6 : 12;
      for (int s = 0; s < n; s++) begin
        step();
        if (noise) begin
          valid = ~valid;
          d_in  = d_in + 8'h11;
          chk("ready_held", ready, 1'b0);
        end
      end
      chk($sformatf("bit%0d_of_%02h", k, b), tx, e);
      if (k >= 1 && k <= 8) rx[k-1] = tx;
    end
    chk("rx_byte", rx, b);
    if (noise) valid = 1'b0;
    repeat (5) step();
    chk("done_early", done, 1'b0);
    chk("stop_high", tx, 1'b1);
    step();
    chk("done_pulse", done, 1'b1);
    chk("ready_back", ready, 1'b1);
    chk("busy_clear", busy, 1'b0);
    chk("line_idle", tx, 1'b1);
    step();
    chk("done_one_cycle", done, 1'b0);
  endtask

  task automatic send(input logic [7:0] b);
    valid = 1'b1;
    d_in  = b;
    step();
    valid = 1'b0;
    chk("line_falls", tx, 1'b0);
    chk("ready_drops", ready, 1'b0);
    chk("busy_set", busy, 1'b1);
  endtask

  initial begin
    int snap;
    int n;
    tests    = 0;
    fails    = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    valid    = 1'b0;
    d_in     = 8'h00;
    valid2   = 1'b0;
    d_in2    = 8'h00;
    repeat (3) step();
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 200; i++) begin
      step();
      chk("idle_tx", tx, 1'b1);
      chk("idle_ready", ready, 1'b1);
      chk("idle_busy", busy, 1'b0);
    end

    send(8'hA5);
    frame(8'hA5, 1'b0);

    // back-to-back with valid held high
    valid = 1'b1;
    d_in  = 8'h00;
    step();
    chk("b2b_fall0", tx, 1'b0);
    d_in = 8'hFF;
    frame(8'h00, 1'b0);
    chk("b2b_gap_end", tx, 1'b0);
    chk("b2b_ready", ready, 1'b0);
    valid = 1'b0;
    frame(8'hFF, 1'b0);
    chk("b2b_no_dup", busy, 1'b0);

    send(8'h3C);
    frame(8'h3C, 1'b1);
    chk("noise_no_accept", busy, 1'b0);

    // reset 50 cycles into a frame
    send(8'hC3);
    repeat (49) step();
    snap  = done_cnt;
    rst_n = 1'b0;
    step();
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", ready, 1'b1);
    rst_n = 1'b1;
    repeat (130) step();
    chk("midrst_no_done", done_cnt, snap);
    chk("midrst_idle", tx, 1'b1);

    // reset wins over a simultaneous handshake
    valid = 1'b1;
    d_in  = 8'h77;
    rst_n = 1'b0;
    step();
    valid = 1'b0;
    rst_n = 1'b1;
    chk("rst_vs_hs_busy", busy, 1'b0);
    step();
    chk("rst_vs_hs_tx", tx, 1'b1);
    chk("rst_vs_hs_busy2", busy, 1'b0);

    send(8'h5A);
    frame(8'h5A, 1'b0);

    for (int i = 0; i < 256; i++) begin
      send(8'(i));
      frame(8'(i), 1'b0);
    end
    chk("done_total", done_cnt, 261);

    // two stop bits: 132 cycles from line fall to done
    valid2 = 1'b1;
    d_in2  = 8'h96;
    step();
    valid2 = 1'b0;
    chk("sb2_fall", tx2, 1'b0);
    n = 0;
    while (!done2 && n < 200) begin
      step();
      n++;
    end
    chk("sb2_frame_len", n, 132);
    chk("sb2_idle", busy2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
